// File: rtl/core_pkg.sv
// Shared core definitions: special instruction encodings, hazard FSM states
// and the scoreboard slot layout used by the pipeline control logic.
package core_pkg;

  localparam logic [15:0] INST_NOP  = 16'h0800;
  localparam logic [15:0] INST_HALT = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SHADOW,
    ST_HALT
  } ctrlState_t;

  typedef struct packed {
    logic       v;
    logic [2:0] regNum;
  } sbSlot_t;

  // True when a valid in-flight destination matches a source actually read in ID.
  function automatic logic slotHit(input sbSlot_t slot,
                                   input logic [2:0] rs, input logic usesRs,
                                   input logic [2:0] rt, input logic usesRt);
    return slot.v & ((usesRs & (slot.regNum == rs)) | (usesRt & (slot.regNum == rt)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX, MEM, WB) record of in-flight register writes and the
// read-after-write match against the instruction currently in ID.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int CHECK_WB = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic       issue,
  input  logic [2:0] wrReg,
  input  logic       idNop,
  input  logic [2:0] rs,
  input  logic       usesRs,
  input  logic [2:0] rt,
  input  logic       usesRt,
  output logic       raw
);

  sbSlot_t    slotReg [3];
  logic [2:0] hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotReg[0] <= '0;
      slotReg[1] <= '0;
      slotReg[2] <= '0;
    end else if (!freeze) begin
      slotReg[0] <= '{v: issue, regNum: wrReg};
      slotReg[1] <= slotReg[0];
      slotReg[2] <= slotReg[1];
    end
  end

  // Slot 2 is WB; it only blocks when the register file lacks write-through.
  for (genvar gi = 0; gi < 3; gi++) begin : gHit
    if (gi == 2 && CHECK_WB == 0) begin : gOff
      assign hit[gi] = 1'b0;
    end else begin : gOn
      assign hit[gi] = slotHit(slotReg[gi], rs, usesRs, rt, usesRt);
    end
  end

  assign raw = ~idNop & (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: RAW stalls, control-transfer shadow
// flushes, memory freezes, sticky HALT and a saturating stall counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int BR_SHADOW = 2,
  parameter int CHECK_WB  = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id_inst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [2:0]       id_wr_reg,
  input  logic             id_ctrl_xfer,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] SHD_INIT = 3'(BR_SHADOW);

  ctrlState_t       stateReg, stateNext;
  logic [2:0]       shdCntReg, shdCntNext;
  logic             haltedReg, haltedNext;
  logic [CNT_W-1:0] stallCntReg;

  logic idNop, isHalt, issue, raw;

  assign idNop  = (id_inst == INST_NOP) | ~id_valid;
  assign isHalt = id_valid & (id_inst == INST_HALT);
  assign issue  = id_valid & id_wr_en & ~id_ex_bubble;

  hazard_scoreboard #(
    .CHECK_WB(CHECK_WB)
  ) uScoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (mem_busy),
    .issue  (issue),
    .wrReg  (id_wr_reg),
    .idNop  (idNop),
    .rs     (id_rs),
    .usesRs (id_uses_rs),
    .rt     (id_rt),
    .usesRt (id_uses_rt),
    .raw    (raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= ST_RUN;
      shdCntReg <= '0;
      haltedReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      shdCntReg <= shdCntNext;
      haltedReg <= haltedNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    shdCntNext   = shdCntReg;
    haltedNext   = haltedReg;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_busy) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
    end else begin
      case (stateReg)
        ST_HALT: begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
        ST_SHADOW: begin
          if_id_flush = 1'b1;
          shdCntNext  = shdCntReg - 3'd1;
          if (shdCntReg <= 3'd1) begin
            stateNext  = ST_RUN;
            shdCntNext = 3'd0;
          end
        end
        ST_RUN: begin
          if (raw) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_ctrl_xfer & ~idNop) begin
            // The transfer itself proceeds; flushing starts on the next cycle.
            stateNext  = ST_SHADOW;
            shdCntNext = SHD_INIT;
          end else if (isHalt) begin
            stateNext  = ST_HALT;
            haltedNext = 1'b1;
          end
        end
        default: stateNext = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= '0;
    end else if (pc_hold && (stallCntReg != {CNT_W{1'b1}})) begin
      stallCntReg <= stallCntReg + CNT_W'(1);
    end
  end

  assign halted    = haltedReg;
  assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (CHECK_WB=0, CHECK_WB=1,
// 4-bit counter) share directed stimulus; a negedge monitor checks queued expectations.
module tb_hazard_ctrl;

  localparam logic [4:0] E_IDLE   = 5'b00000; // {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, halted}
  localparam logic [4:0] E_STALL  = 5'b11010;
  localparam logic [4:0] E_FLUSH  = 5'b00100;
  localparam logic [4:0] E_FREEZE = 5'b11000;
  localparam logic [4:0] E_HALT   = 5'b11011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_inst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_wr_reg;
  logic        id_uses_rs, id_uses_rt, id_wr_en, id_ctrl_xfer, mem_busy;

  logic [2:0]  pcHold, ifIdHold, ifIdFlush, bubble, haltedO;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  typedef struct {
    int         dut;
    logic [4:0] ctl;
    int         cnt;
    int         stepNo;
  } expRec_t;

  expRec_t expQ[$];
  expRec_t rec;
  int      expCnt [3];
  int      maxCnt [3];
  int      stepNo;
  int      checks;
  int      failures;

  always #5 clk = ~clk;

  hazard_ctrl #(.BR_SHADOW(2), .CHECK_WB(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_ctrl_xfer(id_ctrl_xfer), .mem_busy(mem_busy),
    .pc_hold(pcHold[0]), .if_id_hold(ifIdHold[0]), .if_id_flush(ifIdFlush[0]),
    .id_ex_bubble(bubble[0]), .halted(haltedO[0]), .stall_cnt(cnt0));

  hazard_ctrl #(.BR_SHADOW(2), .CHECK_WB(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_ctrl_xfer(id_ctrl_xfer), .mem_busy(mem_busy),
    .pc_hold(pcHold[1]), .if_id_hold(ifIdHold[1]), .if_id_flush(ifIdFlush[1]),
    .id_ex_bubble(bubble[1]), .halted(haltedO[1]), .stall_cnt(cnt1));

  hazard_ctrl #(.BR_SHADOW(2), .CHECK_WB(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_ctrl_xfer(id_ctrl_xfer), .mem_busy(mem_busy),
    .pc_hold(pcHold[2]), .if_id_hold(ifIdHold[2]), .if_id_flush(ifIdFlush[2]),
    .id_ex_bubble(bubble[2]), .halted(haltedO[2]), .stall_cnt(cnt2));

  // Drive one cycle of ID inputs, queue the expected outputs for each instance, advance.
  task automatic step(input logic v, input logic [15:0] inst,
                      input logic [2:0] rs, input logic uRs,
                      input logic [2:0] rt, input logic uRt,
                      input logic wen, input logic [2:0] wr,
                      input logic xf, input logic busy,
                      input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
    logic [4:0] e [3];
    expRec_t r;
    e[0] = e0; e[1] = e1; e[2] = e2;
    id_valid = v; id_inst = inst; id_rs = rs; id_uses_rs = uRs;
    id_rt = rt; id_uses_rt = uRt; id_wr_en = wen; id_wr_reg = wr;
    id_ctrl_xfer = xf; mem_busy = busy;
    for (int d = 0; d < 3; d++) begin
      r.dut = d; r.ctl = e[d]; r.cnt = expCnt[d]; r.stepNo = stepNo;
      expQ.push_back(r);
      if (e[d][4] && expCnt[d] < maxCnt[d]) expCnt[d] = expCnt[d] + 1;
    end
    stepNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic stepIdle(input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
    step(1'b0, 16'h1234, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, e0, e1, e2);
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      logic [4:0] actCtl;
      int         actCnt;
      rec = expQ.pop_front();
      actCtl = {pcHold[rec.dut], ifIdHold[rec.dut], ifIdFlush[rec.dut], bubble[rec.dut], haltedO[rec.dut]};
      actCnt = (rec.dut == 0) ? int'(cnt0) : (rec.dut == 1) ? int'(cnt1) : int'(cnt2);
      checks++;
      if (actCtl !== rec.ctl || actCnt != rec.cnt) begin
        failures++;
        $display("FAIL step%0d dut%0d ctl actual=%b required=%b stall_cnt actual=%0d required=%0d",
                 rec.stepNo, rec.dut, actCtl, rec.ctl, actCnt, rec.cnt);
      end else begin
        $display("step%0d dut%0d ok ctl=%b stall_cnt=%0d", rec.stepNo, rec.dut, actCtl, actCnt);
      end
    end
  end

  initial begin
    checks = 0; failures = 0; stepNo = 0;
    expCnt[0] = 0; expCnt[1] = 0; expCnt[2] = 0;
    maxCnt[0] = 65535; maxCnt[1] = 65535; maxCnt[2] = 15;
    rst_n = 1'b0;
    id_valid = 0; id_inst = 16'h1234; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_wr_en = 0; id_wr_reg = 0; id_ctrl_xfer = 0; mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    stepIdle(E_IDLE, E_IDLE, E_IDLE);
    rst_n = 1'b1;
    stepIdle(E_IDLE, E_IDLE, E_IDLE);

    // Producer of R3, then a dependent ADD: 2 stalls without WB check, 3 with it.
    step(1, 16'h1111, 0, 0, 0, 0, 1, 3, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    step(1, 16'h2345, 3, 1, 5, 1, 1, 4, 0, 0, E_STALL, E_STALL, E_STALL);
    step(1, 16'h2345, 3, 1, 5, 1, 1, 4, 0, 0, E_STALL, E_STALL, E_STALL);
    step(1, 16'h2345, 3, 1, 5, 1, 1, 4, 0, 0, E_IDLE, E_STALL, E_IDLE);
    repeat (4) stepIdle(E_IDLE, E_IDLE, E_IDLE);

    // R0 gets no exemption; dependency seen through Rt only.
    step(1, 16'h1000, 0, 0, 0, 0, 1, 0, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    step(1, 16'h2000, 1, 0, 0, 1, 0, 0, 0, 0, E_STALL, E_STALL, E_STALL);
    step(1, 16'h2000, 1, 0, 0, 1, 0, 0, 0, 0, E_STALL, E_STALL, E_STALL);
    step(1, 16'h2000, 1, 0, 0, 1, 0, 0, 0, 0, E_IDLE, E_STALL, E_IDLE);
    repeat (3) stepIdle(E_IDLE, E_IDLE, E_IDLE);

    // Fill every slot with R2; NOP and invalid instructions never stall.
    repeat (3) step(1, 16'h1200, 0, 0, 0, 0, 1, 2, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    step(1, 16'h0800, 2, 1, 2, 1, 0, 0, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    step(0, 16'h2222, 2, 1, 2, 1, 0, 0, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    step(1, 16'h2222, 2, 1, 2, 1, 0, 0, 0, 0, E_IDLE, E_STALL, E_IDLE);
    repeat (3) stepIdle(E_IDLE, E_IDLE, E_IDLE);

    // Independent branch, memory freeze across the shadow, flush still totals 2.
    step(1, 16'h4000, 0, 0, 0, 0, 0, 0, 1, 0, E_IDLE, E_IDLE, E_IDLE);
    repeat (3) step(1, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 1, E_FREEZE, E_FREEZE, E_FREEZE);
    repeat (2) step(1, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, E_FLUSH, E_FLUSH, E_FLUSH);
    step(1, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE, E_IDLE, E_IDLE);

    // HALT retires and holds the pipe until reset.
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE, E_IDLE, E_IDLE);
    repeat (3) stepIdle(E_HALT, E_HALT, E_HALT);
    rst_n = 1'b0;
    expCnt[0] = 0; expCnt[1] = 0; expCnt[2] = 0;
    stepIdle(E_IDLE, E_IDLE, E_IDLE);
    rst_n = 1'b1;
    stepIdle(E_IDLE, E_IDLE, E_IDLE);

    // Self-dependent chain keeps stalling; 4-bit counter must pin at 15.
    for (int k = 0; k < 30; k++) begin
      step(1, 16'h3666, 6, 1, 0, 0, 1, 6, 0, 0,
           (k % 3 == 0) ? E_IDLE : E_STALL,
           (k % 4 == 0) ? E_IDLE : E_STALL,
           (k % 3 == 0) ? E_IDLE : E_STALL);
    end
    stepIdle(E_IDLE, E_IDLE, E_IDLE);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
